// File: rtl/sky130_sram_1rw1r_arb_ctrl_pkg.sv
// Shared definitions for the sky130 1rw1r SRAM front-end controller.
package sky130_sram_1rw1r_arb_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 80;
   localparam int DEF_ADDR_WIDTH = 6;
   localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

   // Owner of an outstanding port-0 read.
   typedef enum logic {
      OWNER_M0 = 1'b0,
      OWNER_M1 = 1'b1
   } owner_e;

   // Map a one-hot port-0 grant to the owner of the transfer.
   function automatic owner_e owner_of(input logic [1:0] gnt);
      return gnt[1] ? OWNER_M1 : OWNER_M0;
   endfunction

endpackage

// File: rtl/sky130_sram_1rw1r_arb_ctrl_if.sv
// Requester-side bundles: a read/write requester (port 0 sharers) and a
// read-only requester (port 1).
interface sky130_sram_1rw1r_arb_ctrl_rw_if #(
   parameter int DW = 80,
   parameter int AW = 6,
   parameter int MW = 10
);
   logic          valid;
   logic          ready;
   logic          we;
   logic [MW-1:0] wmask;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (output valid, we, wmask, addr, wdata,
                   input  ready, rvalid, rdata);
   modport slave  (input  valid, we, wmask, addr, wdata,
                   output ready, rvalid, rdata);
endinterface

interface sky130_sram_1rw1r_arb_ctrl_rd_if #(
   parameter int DW = 80,
   parameter int AW = 6
);
   logic          valid;
   logic          ready;
   logic [AW-1:0] addr;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (output valid, addr, input ready, rvalid, rdata);
   modport slave  (input valid, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/sky130_sram_1rw1r_arb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins
// the next tie and moves to the loser after every grant.
module sram_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   logic r_ptr;

   assign o_gnt[0] = i_req[0] & (~i_req[1] | ~r_ptr);
   assign o_gnt[1] = i_req[1] & (~i_req[0] |  r_ptr);

   // Pointer update: hand priority to the requester that did not win.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (|o_gnt) begin
         r_ptr <= o_gnt[0];
      end
   end

endmodule

// File: rtl/sky130_sram_1rw1r_arb_ctrl.sv
// Front end for one sky130 OpenRAM 1rw1r macro: M0/M1 share port 0 via
// round-robin, M2 owns port 1 and stalls on a same-address port-0 write.
module sky130_sram_1rw1r_arb_ctrl
   import sky130_sram_1rw1r_arb_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sky130_sram_1rw1r_arb_ctrl_rw_if.slave m0,
   sky130_sram_1rw1r_arb_ctrl_rw_if.slave m1,
   sky130_sram_1rw1r_arb_ctrl_rd_if.slave m2,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
);

   logic [1:0]            w_req;
   logic [1:0]            w_gnt;
   logic                  w_gnt_any;
   owner_e                w_sel;
   logic                  w_we_sel;
   logic [ADDR_WIDTH-1:0] w_addr_sel;
   logic                  w_wr_gnt;
   logic                  w_rd_gnt;
   logic                  w_m2_acc;

   logic                  r_rd_pend0;
   owner_e                r_rd_owner0;
   logic                  r_rd_pend2;

   // Requests are masked while in reset so the macro stays deselected.
   assign w_req = {m1.valid & rst_n, m0.valid & rst_n};

   sram_rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (w_req),
      .o_gnt (w_gnt)
   );

   assign w_gnt_any  = |w_gnt;
   assign w_sel      = owner_of(w_gnt);
   assign w_we_sel   = (w_sel == OWNER_M1) ? m1.we   : m0.we;
   assign w_addr_sel = (w_sel == OWNER_M1) ? m1.addr : m0.addr;
   assign w_wr_gnt   = w_gnt_any &  w_we_sel;
   assign w_rd_gnt   = w_gnt_any & ~w_we_sel;

   assign m0.ready = w_gnt[0];
   assign m1.ready = w_gnt[1];

   // Port-0 macro drive from the granted requester; idle values otherwise.
   always_comb begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = '0;
      sram_addr0  = '0;
      sram_din0   = '0;
      if (w_gnt_any) begin
         sram_csb0  = 1'b0;
         sram_web0  = ~w_we_sel;
         sram_addr0 = w_addr_sel;
         if (w_sel == OWNER_M1) begin
            sram_din0   = m1.wdata;
            sram_wmask0 = m1.we ? m1.wmask : '0;
         end else begin
            sram_din0   = m0.wdata;
            sram_wmask0 = m0.we ? m0.wmask : '0;
         end
      end
   end

   // M2 waits a cycle when port 0 writes the same word, so it never sees
   // the macro's undefined read-during-write result.
   assign w_m2_acc   = rst_n & m2.valid & ~(w_wr_gnt && (m2.addr == w_addr_sel));
   assign m2.ready   = w_m2_acc;
   assign sram_csb1  = ~w_m2_acc;
   assign sram_addr1 = w_m2_acc ? m2.addr : '0;

   // Remember who owns the read data arriving next cycle on each port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_pend0  <= 1'b0;
         r_rd_owner0 <= OWNER_M0;
         r_rd_pend2  <= 1'b0;
      end else begin
         r_rd_pend0 <= w_rd_gnt;
         r_rd_pend2 <= w_m2_acc;
         if (w_rd_gnt) begin
            r_rd_owner0 <= w_sel;
         end
      end
   end

   assign m0.rvalid = r_rd_pend0 & (r_rd_owner0 == OWNER_M0);
   assign m1.rvalid = r_rd_pend0 & (r_rd_owner0 == OWNER_M1);
   assign m0.rdata  = sram_dout0;
   assign m1.rdata  = sram_dout0;
   assign m2.rvalid = r_rd_pend2;
   assign m2.rdata  = sram_dout1;

endmodule

// File: tb/tb_sky130_sram_1rw1r_arb_ctrl.sv
// Bench for the 1rw1r SRAM front end: behavioural macro, table vectors,
// hand sequences for reset, then random traffic against a reference model.
module tb_sky130_sram_1rw1r_arb_ctrl;

   localparam int DW = 80;
   localparam int AW = 6;
   localparam int MW = 10;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sky130_sram_1rw1r_arb_ctrl_rw_if #(.DW(DW), .AW(AW), .MW(MW)) m0_if ();
   sky130_sram_1rw1r_arb_ctrl_rw_if #(.DW(DW), .AW(AW), .MW(MW)) m1_if ();
   sky130_sram_1rw1r_arb_ctrl_rd_if #(.DW(DW), .AW(AW)) m2_if ();

   logic          sram_csb0, sram_web0, sram_csb1;
   logic [MW-1:0] sram_wmask0;
   logic [AW-1:0] sram_addr0, sram_addr1;
   logic [DW-1:0] sram_din0;
   logic [DW-1:0] sram_dout0 = '0;
   logic [DW-1:0] sram_dout1 = '0;

   sky130_sram_1rw1r_arb_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .m0          (m0_if),
      .m1          (m1_if),
      .m2          (m2_if),
      .sram_csb0   (sram_csb0),
      .sram_web0   (sram_web0),
      .sram_wmask0 (sram_wmask0),
      .sram_addr0  (sram_addr0),
      .sram_din0   (sram_din0),
      .sram_dout0  (sram_dout0),
      .sram_csb1   (sram_csb1),
      .sram_addr1  (sram_addr1),
      .sram_dout1  (sram_dout1)
   );

   function automatic logic [DW-1:0] init_val(input int i);
      logic [7:0] b;
      b = 8'(i * 37 + 5);
      return {10{b}};
   endfunction

   // Behavioural macro: synchronous on both ports, masked byte writes.
   logic [DW-1:0] sram_mem [DEPTH];
   always @(posedge clk) begin
      logic [DW-1:0] w;
      if (!sram_csb0) begin
         if (!sram_web0) begin
            w = sram_mem[sram_addr0];
            for (int b = 0; b < MW; b++)
               if (sram_wmask0[b]) w[b*8 +: 8] = sram_din0[b*8 +: 8];
            sram_mem[sram_addr0] <= w;
         end else begin
            sram_dout0 <= sram_mem[sram_addr0];
         end
      end
      if (!sram_csb1) sram_dout1 <= sram_mem[sram_addr1];
   end

   // Reference model state
   logic [DW-1:0] ref_mem [DEPTH];
   int            tie_winner;
   bit            e_pv, e_2v;
   int            e_po;
   logic [DW-1:0] e_pd, e_2d;
   bit            last_g0, last_g1, last_r2;
   int            n_pass = 0;
   int            n_total = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One clock cycle: compare at the negedge, then advance the model.
   task automatic cycle(input bit has_exp, input bit [5:0] ex, input string tag);
      bit v0, v1, v2, g0, g1, gwe, wr, r2;
      logic [AW-1:0] ga, a2;
      logic [DW-1:0] gd, w;
      logic [MW-1:0] gm;
      @(negedge clk);
      v0 = m0_if.valid; v1 = m1_if.valid; v2 = m2_if.valid; a2 = m2_if.addr;
      if (!rst_n) begin
         v0 = 0; v1 = 0; v2 = 0; e_pv = 0; e_2v = 0; tie_winner = 0;
      end
      if (v0 && v1) begin g0 = (tie_winner == 0); g1 = !g0; end
      else begin g0 = v0; g1 = v1; end
      gwe = 0; ga = '0; gd = '0; gm = '0;
      if (g0) begin gwe = m0_if.we; ga = m0_if.addr; gd = m0_if.wdata; gm = m0_if.we ? m0_if.wmask : '0; end
      if (g1) begin gwe = m1_if.we; ga = m1_if.addr; gd = m1_if.wdata; gm = m1_if.we ? m1_if.wmask : '0; end
      wr = (g0 || g1) && gwe;
      r2 = v2 && !(wr && a2 == ga);

      chk({tag, " m0_ready"}, m0_if.ready, g0);
      chk({tag, " m1_ready"}, m1_if.ready, g1);
      chk({tag, " m2_ready"}, m2_if.ready, r2);
      chk({tag, " csb0"}, sram_csb0, !(g0 || g1));
      chk({tag, " web0"}, sram_web0, !wr);
      chk({tag, " wmask0"}, sram_wmask0, gm);
      chk({tag, " addr0"}, sram_addr0, ga);
      chk({tag, " din0"}, sram_din0, gd);
      chk({tag, " csb1"}, sram_csb1, !r2);
      chk({tag, " addr1"}, sram_addr1, r2 ? a2 : '0);
      chk({tag, " m0_rvalid"}, m0_if.rvalid, e_pv && e_po == 0);
      chk({tag, " m1_rvalid"}, m1_if.rvalid, e_pv && e_po == 1);
      chk({tag, " m2_rvalid"}, m2_if.rvalid, e_2v);
      if (e_pv && e_po == 0) chk({tag, " m0_rdata"}, m0_if.rdata, e_pd);
      if (e_pv && e_po == 1) chk({tag, " m1_rdata"}, m1_if.rdata, e_pd);
      if (e_2v) chk({tag, " m2_rdata"}, m2_if.rdata, e_2d);
      if (has_exp) begin
         chk({tag, " tbl_m0_ready"}, m0_if.ready, ex[5]);
         chk({tag, " tbl_m1_ready"}, m1_if.ready, ex[4]);
         chk({tag, " tbl_m2_ready"}, m2_if.ready, ex[3]);
         chk({tag, " tbl_csb0"}, sram_csb0, ex[2]);
         chk({tag, " tbl_web0"}, sram_web0, ex[1]);
         chk({tag, " tbl_csb1"}, sram_csb1, ex[0]);
      end

      @(posedge clk);
      e_pv = (g0 || g1) && !gwe;
      e_po = g1 ? 1 : 0;
      if (e_pv) e_pd = ref_mem[ga];
      e_2v = r2;
      if (r2) e_2d = ref_mem[a2];
      if (wr) begin
         w = ref_mem[ga];
         for (int b = 0; b < MW; b++)
            if (gm[b]) w[b*8 +: 8] = gd[b*8 +: 8];
         ref_mem[ga] = w;
      end
      if (g0) tie_winner = 1;
      else if (g1) tie_winner = 0;
      last_g0 = g0; last_g1 = g1; last_r2 = r2;
      #1;
   endtask

   typedef struct {
      bit            av, awe; int aa; logic [DW-1:0] ad; logic [MW-1:0] am;
      bit            bv, bwe; int ba; logic [DW-1:0] bd; logic [MW-1:0] bm;
      bit            cv;      int ca;
      bit [5:0]      ex;      // m0_ready m1_ready m2_ready csb0 web0 csb1
      int            rs;      // response owner to check next cycle: 0 none, 1..3 = M0..M2
      logic [DW-1:0] rd;
   } vec_t;

   function automatic vec_t mk(bit av, bit awe, int aa, logic [DW-1:0] ad, logic [MW-1:0] am,
                               bit bv, bit bwe, int ba, logic [DW-1:0] bd, logic [MW-1:0] bm,
                               bit cv, int ca, bit [5:0] ex, int rs, logic [DW-1:0] rd);
      vec_t v;
      v.av = av; v.awe = awe; v.aa = aa; v.ad = ad; v.am = am;
      v.bv = bv; v.bwe = bwe; v.ba = ba; v.bd = bd; v.bm = bm;
      v.cv = cv; v.ca = ca; v.ex = ex; v.rs = rs; v.rd = rd;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      m0_if.valid = v.av; m0_if.we = v.awe; m0_if.addr = AW'(v.aa); m0_if.wdata = v.ad; m0_if.wmask = v.am;
      m1_if.valid = v.bv; m1_if.we = v.bwe; m1_if.addr = AW'(v.ba); m1_if.wdata = v.bd; m1_if.wmask = v.bm;
      m2_if.valid = v.cv; m2_if.addr = AW'(v.ca);
   endtask

   task automatic rand_drive();
      logic [95:0] r;
      if (!(m0_if.valid && !last_g0)) begin
         r = {$urandom(), $urandom(), $urandom()};
         m0_if.valid = ($urandom_range(0, 3) != 0); m0_if.we = $urandom_range(0, 1) == 1;
         m0_if.addr = AW'($urandom_range(0, 7)); m0_if.wdata = r[DW-1:0]; m0_if.wmask = MW'($urandom());
      end
      if (!(m1_if.valid && !last_g1)) begin
         r = {$urandom(), $urandom(), $urandom()};
         m1_if.valid = ($urandom_range(0, 3) != 0); m1_if.we = $urandom_range(0, 1) == 1;
         m1_if.addr = AW'($urandom_range(0, 7)); m1_if.wdata = r[DW-1:0]; m1_if.wmask = MW'($urandom());
      end
      if (!(m2_if.valid && !last_r2)) begin
         m2_if.valid = ($urandom_range(0, 2) != 0); m2_if.addr = AW'($urandom_range(0, 7));
      end
   endtask

   localparam logic [DW-1:0] D5  = 80'h1234_5678_9ABC_DEF0_1122;
   localparam logic [DW-1:0] D9  = 80'hCAFE_F00D_0BAD_BEEF_5A5A;
   localparam logic [DW-1:0] D9B = 80'h0F0F_1E1E_2D2D_3C3C_4B4B;
   localparam logic [DW-1:0] FF  = {10{8'hFF}};
   localparam logic [DW-1:0] BM  = {{9{8'hFF}}, 8'h00};

   vec_t tbl [17];

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         sram_mem[i] = init_val(i);
         ref_mem[i]  = init_val(i);
      end
      tie_winner = 0; e_pv = 0; e_2v = 0; e_po = 0; e_pd = '0; e_2d = '0;
      last_g0 = 0; last_g1 = 0; last_r2 = 0;

      tbl[0]  = mk(0,0,0,'0,'0,     0,0,0,'0,'0, 0,0,  6'b000111, 0, '0);
      tbl[1]  = mk(1,1,5,D5,10'h3FF, 0,0,0,'0,'0, 0,0,  6'b100001, 0, '0);
      tbl[2]  = mk(0,0,0,'0,'0,     1,0,5,'0,'0, 0,0,  6'b010011, 2, D5);
      tbl[3]  = mk(1,1,7,FF,10'h3FF, 0,0,0,'0,'0, 0,0,  6'b100001, 0, '0);
      tbl[4]  = mk(1,1,7,'0,10'h001, 0,0,0,'0,'0, 0,0,  6'b100001, 0, '0);
      tbl[5]  = mk(1,0,7,'0,'0,     0,0,0,'0,'0, 0,0,  6'b100011, 1, BM);
      tbl[6]  = mk(1,1,9,D9,10'h3FF, 0,0,0,'0,'0, 1,9,  6'b100001, 0, '0);
      tbl[7]  = mk(0,0,0,'0,'0,     0,0,0,'0,'0, 1,9,  6'b001110, 3, D9);
      tbl[8]  = mk(1,1,9,D9B,10'h3FF,0,0,0,'0,'0, 1,10, 6'b101000, 3, init_val(10));
      tbl[9]  = mk(0,0,0,'0,'0,     1,0,3,'0,'0, 1,4,  6'b011010, 2, init_val(3));
      tbl[10] = mk(0,0,0,'0,'0,     0,0,0,'0,'0, 0,0,  6'b000111, 0, '0);
      for (int i = 11; i < 17; i++)
         if (i % 2 == 1) tbl[i] = mk(1,0,1,'0,'0, 1,0,2,'0,'0, 0,0, 6'b100011, 1, init_val(1));
         else            tbl[i] = mk(1,0,1,'0,'0, 1,0,2,'0,'0, 0,0, 6'b010011, 2, init_val(2));

      apply(tbl[0]);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset csb0", sram_csb0, 1'b1);
      chk("reset csb1", sram_csb1, 1'b1);
      chk("reset web0", sram_web0, 1'b1);
      chk("reset m0_rvalid", m0_if.rvalid, 1'b0);
      chk("reset m2_rvalid", m2_if.rvalid, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         apply(tbl[i]);
         cycle(1'b1, tbl[i].ex, $sformatf("vec%0d", i));
         case (tbl[i].rs)
            1: begin chk($sformatf("vec%0d rsp m0_rvalid", i), m0_if.rvalid, 1'b1);
                     chk($sformatf("vec%0d rsp m0_rdata", i), m0_if.rdata, tbl[i].rd); end
            2: begin chk($sformatf("vec%0d rsp m1_rvalid", i), m1_if.rvalid, 1'b1);
                     chk($sformatf("vec%0d rsp m0_quiet", i), m0_if.rvalid, 1'b0);
                     chk($sformatf("vec%0d rsp m1_rdata", i), m1_if.rdata, tbl[i].rd); end
            3: begin chk($sformatf("vec%0d rsp m2_rvalid", i), m2_if.rvalid, 1'b1);
                     chk($sformatf("vec%0d rsp m2_rdata", i), m2_if.rdata, tbl[i].rd); end
            default: ;
         endcase
      end

      // Reset in the middle of a read: the pending response must vanish and
      // the round-robin pointer must return to M0.
      apply(mk(1,0,1,'0,'0, 1,0,2,'0,'0, 1,4, 6'b0, 0, '0));
      cycle(1'b0, 6'b0, "pre_rst");
      rst_n = 1'b0;
      #1;
      chk("midrst m0_rvalid", m0_if.rvalid, 1'b0);
      chk("midrst m2_rvalid", m2_if.rvalid, 1'b0);
      chk("midrst csb0", sram_csb0, 1'b1);
      chk("midrst csb1", sram_csb1, 1'b1);
      chk("midrst web0", sram_web0, 1'b1);
      cycle(1'b0, 6'b0, "in_rst0");
      cycle(1'b0, 6'b0, "in_rst1");
      rst_n = 1'b1;
      #1;
      chk("first tie m0_ready", m0_if.ready, 1'b1);
      chk("first tie m1_ready", m1_if.ready, 1'b0);
      cycle(1'b0, 6'b0, "post_rst");
      chk("post_rst no stale m1_rvalid", m1_if.rvalid, 1'b0);

      for (int n = 0; n < 400; n++) begin
         rand_drive();
         cycle(1'b0, 6'b0, $sformatf("rnd%0d", n));
      end

      apply(tbl[0]);
      cycle(1'b0, 6'b0, "drain0");
      cycle(1'b0, 6'b0, "drain1");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
